// File: rtl/image_pkg.sv
// image_pkg: shared pixel/address types and snapshot FSM states for the
// frame snapshot buffer and the downstream UART image sender.
//   PIXEL_W    : RGB444 pixel width
//   ADDR_W     : frame RAM address width (up to 2^17 pixels)
//   MAX_PIXELS : largest frame the address width can hold
//   sat_inc8   : 8-bit increment that sticks at 255
package image_pkg;

   localparam int PIXEL_W    = 12;
   localparam int ADDR_W     = 17;
   localparam int MAX_PIXELS = 1 << ADDR_W;

   typedef logic [PIXEL_W-1:0] pixel_t;
   typedef logic [ADDR_W-1:0]  addr_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_CAPTURE,
      S_HOLD
   } snap_state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/frame_snapshot_buffer_if.sv
// frame_snapshot_buffer_if: camera pixel stream plus sender read bus.
//   frame_start : 1-cycle start-of-frame pulse from the camera
//   pix_valid   : pix_data valid this cycle
//   pix_data    : camera pixel, RGB444
//   rd_address  : read address from the image sender
//   rd_pixel    : pixel at rd_address, one cycle later
//   send_done   : sender's image-sent level
//   frame_ready : a complete frame is being held
// master = camera/sender side, slave = snapshot buffer.
interface frame_snapshot_buffer_if;
   import image_pkg::*;

   logic   frame_start;
   logic   pix_valid;
   pixel_t pix_data;
   addr_t  rd_address;
   pixel_t rd_pixel;
   logic   send_done;
   logic   frame_ready;

   modport master (
      output frame_start, pix_valid, pix_data, rd_address, send_done,
      input  rd_pixel, frame_ready
   );

   modport slave (
      input  frame_start, pix_valid, pix_data, rd_address, send_done,
      output rd_pixel, frame_ready
   );

endinterface

// File: rtl/snapshot_ram.sv
// snapshot_ram: simple dual-port frame RAM, DEPTH x PIXEL_W.
//   clk     : clock
//   rst     : synchronous active-high reset of the read register only
//   we      : write enable
//   wr_addr : write address (writes beyond DEPTH are dropped)
//   wr_data : write data
//   rd_addr : read address
//   rd_data : registered read data; 0 for rd_addr >= DEPTH
module snapshot_ram
   import image_pkg::*;
#(
   parameter int DEPTH = 100
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   we,
   input  addr_t  wr_addr,
   input  pixel_t wr_data,
   input  addr_t  rd_addr,
   output pixel_t rd_data
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   pixel_t           mem [DEPTH];
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   logic             wr_in_range;
   logic             rd_in_range;

   assign wr_idx      = wr_addr[IDX_W-1:0];
   assign rd_idx      = rd_addr[IDX_W-1:0];
   // 32-bit compare so DEPTH = 2^17 does not truncate to zero
   assign wr_in_range = 32'(wr_addr) < 32'(DEPTH);
   assign rd_in_range = 32'(rd_addr) < 32'(DEPTH);

   always_ff @(posedge clk) begin
      if (we && wr_in_range) begin
         mem[wr_idx] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_in_range) begin
         rd_data <= mem[rd_idx];
      end else begin
         rd_data <= '0;
      end
   end

endmodule

// File: rtl/frame_snapshot_buffer.sv
// frame_snapshot_buffer: captures one camera frame into RAM and freezes it
// until the image sender reports the whole image has been sent.
//   clk          : system clock
//   rst          : synchronous active-high reset (RAM contents kept)
//   capture_en   : level, permits arming for a new capture
//   bus          : frame_snapshot_buffer_if.slave (pixel stream + read bus)
//   frame_count  : completed captures, wraps 255->0
//   short_frames : captures restarted by an early frame_start, saturates
// Optional build macro SUBSAMPLE_EN: camera frame is 2*IMG_WIDTH wide and
// twice as tall; only pixels at even column and even row are stored.
module frame_snapshot_buffer
   import image_pkg::*;
#(
   parameter int NUM_PIXELS = 100,
   parameter int IMG_WIDTH  = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   capture_en,
   frame_snapshot_buffer_if.slave bus,
   output logic [7:0]             frame_count,
   output logic [7:0]             short_frames
);

   localparam addr_t LAST_ADDR = addr_t'(NUM_PIXELS - 1);

   if (NUM_PIXELS < 1 || NUM_PIXELS > MAX_PIXELS || IMG_WIDTH < 1) begin : g_bad_cfg
      $error("frame_snapshot_buffer: unsupported NUM_PIXELS/IMG_WIDTH");
   end

   snap_state_t state;
   addr_t       wr_addr;
   addr_t       eff_addr;
   logic        send_done_q;
   logic        send_edge;
   logic        keep;
   logic        we;
   logic        last_write;

   // A frame_start inside a capture restarts it, and the pixel arriving in
   // that same cycle is already the first pixel of the new frame.
   assign eff_addr   = bus.frame_start ? '0 : wr_addr;
   assign we         = (state == S_CAPTURE) && capture_en && keep;
   assign last_write = we && (eff_addr == LAST_ADDR);
   assign send_edge  = bus.send_done && !send_done_q;

`ifdef SUBSAMPLE_EN
   localparam int CAM_W = 2 * IMG_WIDTH;

   logic [17:0] col;
   logic        row_odd;
   logic [17:0] cur_col;
   logic        cur_row_odd;

   // Only row parity matters, so the row counter is a single toggle bit.
   assign cur_col     = bus.frame_start ? '0 : col;
   assign cur_row_odd = bus.frame_start ? 1'b0 : row_odd;
   assign keep        = bus.pix_valid && !cur_col[0] && !cur_row_odd;

   always_ff @(posedge clk) begin
      if (rst) begin
         col     <= '0;
         row_odd <= 1'b0;
      end else if (bus.pix_valid) begin
         if (cur_col == 18'(CAM_W - 1)) begin
            col     <= '0;
            row_odd <= !cur_row_odd;
         end else begin
            col     <= cur_col + 18'd1;
            row_odd <= cur_row_odd;
         end
      end else if (bus.frame_start) begin
         col     <= '0;
         row_odd <= 1'b0;
      end
   end
`else
   assign keep = bus.pix_valid;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_IDLE;
         wr_addr         <= '0;
         bus.frame_ready <= 1'b0;
         frame_count     <= '0;
         short_frames    <= '0;
         send_done_q     <= 1'b0;
      end else begin
         send_done_q <= bus.send_done;
         case (state)
            S_IDLE: begin
               if (capture_en) begin
                  state <= S_ARM;
               end
            end
            S_ARM: begin
               if (!capture_en) begin
                  state <= S_IDLE;
               end else if (bus.frame_start) begin
                  state   <= S_CAPTURE;
                  wr_addr <= '0;
               end
            end
            S_CAPTURE: begin
               if (!capture_en) begin
                  state <= S_IDLE;
               end else begin
                  if (bus.frame_start) begin
                     short_frames <= sat_inc8(short_frames);
                  end
                  if (last_write) begin
                     state           <= S_HOLD;
                     bus.frame_ready <= 1'b1;
                     frame_count     <= frame_count + 8'd1;
                  end
                  wr_addr <= we ? eff_addr + addr_t'(1) : eff_addr;
               end
            end
            S_HOLD: begin
               if (send_edge) begin
                  bus.frame_ready <= 1'b0;
                  state           <= capture_en ? S_ARM : S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   snapshot_ram #(
      .DEPTH (NUM_PIXELS)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we      (we),
      .wr_addr (eff_addr),
      .wr_data (bus.pix_data),
      .rd_addr (bus.rd_address),
      .rd_data (bus.rd_pixel)
   );

endmodule

// File: tb/tb_frame_snapshot_buffer.sv
// tb_frame_snapshot_buffer: scoreboard bench for frame_snapshot_buffer.
// Stimulus pushes expected outputs into a queue; a monitor pops them one
// clock later and compares against the DUT. Expected frame contents come
// from a reference model that filters the camera pixel list directly.
// Honours SUBSAMPLE_EN when defined.
module tb_frame_snapshot_buffer;
   import image_pkg::*;

   localparam int NP = 9;
   localparam int IW = 3;
`ifdef SUBSAMPLE_EN
   localparam int     FRAME_LEN = 4 * NP;
   localparam pixel_t BASE1     = 12'h000;
`else
   localparam int     FRAME_LEN = NP;
   localparam pixel_t BASE1     = 12'h001;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       capture_en;
   logic [7:0] frame_count;
   logic [7:0] short_frames;

   frame_snapshot_buffer_if bus ();

   frame_snapshot_buffer #(
      .NUM_PIXELS (NP),
      .IMG_WIDTH  (IW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .capture_en   (capture_en),
      .bus          (bus),
      .frame_count  (frame_count),
      .short_frames (short_frames)
   );

   always #10 clk = ~clk;

   typedef struct {
      int          kind;   // 0 rd_pixel, 1 frame_ready, 2 frame_count, 3 short_frames
      logic [11:0] exp;
      string       name;
   } chk_t;

   chk_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // reference model state
   pixel_t     mdl_mem [NP];
   logic [7:0] mdl_count = 8'd0;
   logic [7:0] mdl_short = 8'd0;
   bit         mdl_ready = 1'b0;

   function automatic void expect_out(input int kind, input logic [11:0] exp, input string nm);
      chk_t c;
      c.kind = kind;
      c.exp  = exp;
      c.name = nm;
      sb.push_back(c);
   endfunction

   // A completed camera frame: keep the pixels the buffer is meant to store.
   function automatic void model_store(input pixel_t px[$]);
      int k = 0;
      for (int i = 0; i < px.size() && k < NP; i++) begin
         bit take;
`ifdef SUBSAMPLE_EN
         take = ((i % (2 * IW)) % 2 == 0) && ((i / (2 * IW)) % 2 == 0);
`else
         take = 1'b1;
`endif
         if (take) begin
            mdl_mem[k] = px[i];
            k++;
         end
      end
      mdl_count = mdl_count + 8'd1;
      mdl_ready = 1'b1;
   endfunction

   function automatic void model_short();
      mdl_short = (mdl_short == 8'd255) ? 8'd255 : mdl_short + 8'd1;
   endfunction

   function automatic void gen_pattern(output pixel_t px[$], input pixel_t base);
      px = {};
      for (int i = 0; i < FRAME_LEN; i++) begin
`ifdef SUBSAMPLE_EN
         px.push_back(base + pixel_t'((i / (2 * IW)) * 16 + (i % (2 * IW))));
`else
         px.push_back(base + pixel_t'(i));
`endif
      end
   endfunction

   function automatic void gen_random(output pixel_t px[$], input int len);
      px = {};
      for (int i = 0; i < len; i++) px.push_back(pixel_t'($urandom_range(0, 4095)));
   endfunction

   // monitor: compares everything queued before this clock edge
   initial begin
      chk_t        e;
      int          n;
      logic [11:0] act;
      forever begin
         @(posedge clk);
         n = sb.size();
         #1;
         for (int i = 0; i < n; i++) begin
            e = sb.pop_front();
            case (e.kind)
               0:       act = bus.rd_pixel;
               1:       act = {11'd0, bus.frame_ready};
               2:       act = {4'd0, frame_count};
               default: act = {4'd0, short_frames};
            endcase
            checks++;
            if (act !== e.exp) begin
               errors++;
               $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.exp);
            end
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_fs();
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
   endtask

   task automatic send_pixels(input pixel_t px[$], input bit gaps);
      foreach (px[i]) begin
         if (gaps) repeat ($urandom_range(0, 2)) tick();
         bus.pix_valid = 1'b1;
         bus.pix_data  = px[i];
         tick();
         bus.pix_valid = 1'b0;
      end
   endtask

   task automatic rd(input addr_t a, input pixel_t exp, input string nm);
      bus.rd_address = a;
      expect_out(0, exp, nm);
      tick();
   endtask

   task automatic check_status(input string nm);
      expect_out(1, {11'd0, mdl_ready}, {nm, " frame_ready"});
      expect_out(2, {4'd0, mdl_count}, {nm, " frame_count"});
      expect_out(3, {4'd0, mdl_short}, {nm, " short_frames"});
      tick();
   endtask

   task automatic read_frame(input string nm);
      int order[$];
      int j, t;
      for (int i = 0; i < NP; i++) order.push_back(i);
      for (int i = NP - 1; i > 0; i--) begin
         j        = $urandom_range(0, i);
         t        = order[i];
         order[i] = order[j];
         order[j] = t;
      end
      foreach (order[i]) rd(addr_t'(order[i]), mdl_mem[order[i]], $sformatf("%s rd[%0d]", nm, order[i]));
      rd(addr_t'(NP), 12'h000, {nm, " rd out of range"});
      rd(17'h1FFFF, 12'h000, {nm, " rd max addr"});
   endtask

   // fresh send_done edge: frame_ready must be low right after that edge
   task automatic release_hold(input string nm);
      bus.send_done = 1'b1;
      mdl_ready     = 1'b0;
      expect_out(1, 12'h000, {nm, " frame_ready drop"});
      tick();
      bus.send_done = 1'b0;
      tick();
   endtask

   task automatic quick_frame();
      pixel_t px[$];
      gen_random(px, FRAME_LEN);
      pulse_fs();
      send_pixels(px, 1'b0);
      model_store(px);
      tick();
      release_hold("quick");
   endtask

   initial begin
      pixel_t px[$];
      pixel_t junk[$];
      bit     abort;

      rst             = 1'b1;
      capture_en      = 1'b0;
      bus.frame_start = 1'b0;
      bus.pix_valid   = 1'b0;
      bus.pix_data    = '0;
      bus.rd_address  = '0;
      bus.send_done   = 1'b0;
      tick(2);
      rd(addr_t'(0), 12'h000, "reset rd_pixel");
      check_status("reset");
      rst = 1'b0;
      tick();
      check_status("idle");

      // first frame, directed pattern
      capture_en = 1'b1;
      tick(2);
      gen_pattern(px, BASE1);
      pulse_fs();
      send_pixels(px, 1'b0);
      model_store(px);
      tick(2);
      check_status("frame1");
      read_frame("frame1");

      // pixels and frame_start while holding must not disturb the frame
      gen_random(junk, FRAME_LEN);
      pulse_fs();
      send_pixels(junk, 1'b1);
      pulse_fs();
      tick(2);
      check_status("hold ignores input");
      read_frame("hold");
      release_hold("release1");
      check_status("armed again");

      // short frame with send_done already high before the hold begins
      bus.send_done = 1'b1;
      gen_random(junk, 4);
      pulse_fs();
      send_pixels(junk, 1'b1);
      pulse_fs();
      model_short();
      gen_pattern(px, 12'h0A1);
      send_pixels(px, 1'b1);
      model_store(px);
      tick(2);
      check_status("short frame");
      rd(addr_t'(0), mdl_mem[0], "short rd[0] first pixel");
      tick(5);
      check_status("send_done level ignored");
      read_frame("short");
      bus.send_done = 1'b0;
      tick(2);
      check_status("send_done low");
      release_hold("release2");

      // randomized frames, some restarted part way through
      for (int f = 0; f < 6; f++) begin
         abort = 1'($urandom_range(0, 1));
         pulse_fs();
         if (abort) begin
            gen_random(junk, $urandom_range(1, NP - 1));
            send_pixels(junk, 1'b1);
            pulse_fs();
            model_short();
         end
         gen_random(px, FRAME_LEN);
         send_pixels(px, 1'b1);
         model_store(px);
         tick(2);
         check_status($sformatf("rand frame %0d", f));
         for (int r = 0; r < 5; r++) begin
            int a;
            a = $urandom_range(0, NP - 1);
            rd(addr_t'(a), mdl_mem[a], $sformatf("rand frame %0d rd[%0d]", f, a));
         end
         release_hold($sformatf("rand release %0d", f));
      end

      // capture_en dropped mid-capture abandons the frame
      pulse_fs();
      gen_random(junk, 4);
      send_pixels(junk, 1'b0);
      capture_en = 1'b0;
      tick(2);
      check_status("capture_en drop");
      capture_en = 1'b1;
      tick(2);
      gen_random(px, FRAME_LEN);
      pulse_fs();
      send_pixels(px, 1'b1);
      model_store(px);
      tick(2);
      check_status("after re-enable");
      read_frame("re-enable");
      release_hold("release3");

      // short_frames saturation: repeated frame_start inside one capture
      pulse_fs();
      for (int i = 0; i < 260; i++) begin
         pulse_fs();
         model_short();
      end
      gen_random(px, FRAME_LEN);
      send_pixels(px, 1'b0);
      model_store(px);
      tick(2);
      check_status("short_frames saturated");
      release_hold("release4");

      // frame_count wrap
      while (mdl_count != 8'd255) quick_frame();
      check_status("frame_count 255");
      quick_frame();
      check_status("frame_count wrap");

      // reset mid-hold and mid-capture
      gen_random(px, FRAME_LEN);
      pulse_fs();
      send_pixels(px, 1'b0);
      model_store(px);
      tick(2);
      check_status("before rst");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mdl_ready = 1'b0;
      mdl_count = 8'd0;
      mdl_short = 8'd0;
      check_status("rst mid-hold");
      tick(2);
      pulse_fs();
      gen_random(junk, 5);
      send_pixels(junk, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_status("rst mid-capture");
      tick(3);
      check_status("after rst no frame_start");

      tick(3);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d pending, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
